// File: rtl/character_registers.sv
// character_registers: position registers for Pacman and four ghosts, with a
// move engine that queries an external wall map before committing a step,
// plus a registered Pacman/ghost collision flag.
module character_registers #(
    parameter int GRID_W = 22,
    parameter int GRID_H = 16,
    parameter int PAC_X0 = 10,
    parameter int PAC_Y0 = 12,
    parameter int G1_X0  = 9,
    parameter int G1_Y0  = 7,
    parameter int G2_X0  = 10,
    parameter int G2_Y0  = 7,
    parameter int G3_X0  = 11,
    parameter int G3_Y0  = 7,
    parameter int G4_X0  = 10,
    parameter int G4_Y0  = 6
) (
    input  logic       clock_50,
    input  logic       reset,
    input  logic [2:0] character_type,
    output logic [7:0] char_x,
    output logic [7:0] char_y,
    output logic       pacman_orientation,
    input  logic       move_req,
    input  logic [2:0] move_char,
    input  logic [1:0] move_dir,
    output logic       busy,
    output logic       move_ack,
    output logic       move_ok,
    output logic [7:0] wall_x,
    output logic [7:0] wall_y,
    input  logic       wall_in,
    output logic       collision
);

    localparam logic [7:0] W_MAX = 8'(GRID_W - 1);
    localparam logic [7:0] H_MAX = 8'(GRID_H - 1);

    // Index 0 is Pacman, 1..4 are the ghosts.
    localparam logic [4:0][7:0] X_INIT = {8'(G4_X0), 8'(G3_X0), 8'(G2_X0), 8'(G1_X0), 8'(PAC_X0)};
    localparam logic [4:0][7:0] Y_INIT = {8'(G4_Y0), 8'(G3_Y0), 8'(G2_Y0), 8'(G1_Y0), 8'(PAC_Y0)};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [4:0][7:0]  r_pos_x;
    logic [4:0][7:0]  r_pos_y;
    logic [2:0]       r_char;
    logic [1:0]       r_dir;
    logic             r_orient;
    logic [7:0]       r_wall_x;
    logic [7:0]       r_wall_y;
    logic             r_move_ok;
    logic             r_collision;

    logic [7:0]       w_cur_x;
    logic [7:0]       w_cur_y;
    logic [7:0]       w_tgt_x;
    logic [7:0]       w_tgt_y;
    logic             w_dir_ok;
    logic             w_tgt_ok;
    logic             w_hit;

    // Select one of the five position entries; out-of-range selects read 0.
    function automatic logic [7:0] pick8(input logic [2:0] idx, input logic [4:0][7:0] arr);
        case (idx)
            3'd0:    pick8 = arr[0];
            3'd1:    pick8 = arr[1];
            3'd2:    pick8 = arr[2];
            3'd3:    pick8 = arr[3];
            3'd4:    pick8 = arr[4];
            default: pick8 = 8'd0;
        endcase
    endfunction

    // Combinational read port for the character picked by character_type.
    always_comb begin
        char_x = pick8(character_type, r_pos_x);
        char_y = pick8(character_type, r_pos_y);
    end

    // Target cell of the latched move: x wraps around the tunnel, y is bounded.
    always_comb begin
        w_cur_x  = pick8(r_char, r_pos_x);
        w_cur_y  = pick8(r_char, r_pos_y);
        w_tgt_x  = w_cur_x;
        w_tgt_y  = w_cur_y;
        w_dir_ok = 1'b0;
        case (r_dir)
            2'b00: begin
                if (w_cur_y == 8'd0) begin
                    w_dir_ok = 1'b0;
                end else begin
                    w_tgt_y  = w_cur_y - 8'd1;
                    w_dir_ok = 1'b1;
                end
            end
            2'b01: begin
                if (w_cur_y >= H_MAX) begin
                    w_dir_ok = 1'b0;
                end else begin
                    w_tgt_y  = w_cur_y + 8'd1;
                    w_dir_ok = 1'b1;
                end
            end
            2'b10: begin
                w_dir_ok = 1'b1;
                if ((w_cur_x == 8'd0) || (w_cur_x > W_MAX)) begin
                    w_tgt_x = W_MAX;
                end else begin
                    w_tgt_x = w_cur_x - 8'd1;
                end
            end
            2'b11: begin
                w_dir_ok = 1'b1;
                if (w_cur_x >= W_MAX) begin
                    w_tgt_x = 8'd0;
                end else begin
                    w_tgt_x = w_cur_x + 8'd1;
                end
            end
            default: begin
                w_dir_ok = 1'b0;
            end
        endcase
    end

    // A move is worth a wall query only for a real character and an in-grid target.
    assign w_tgt_ok = w_dir_ok & (r_char <= 3'd4);

    // Any ghost on the Pacman cell.
    assign w_hit = ((r_pos_x[1] == r_pos_x[0]) && (r_pos_y[1] == r_pos_y[0])) ||
                   ((r_pos_x[2] == r_pos_x[0]) && (r_pos_y[2] == r_pos_y[0])) ||
                   ((r_pos_x[3] == r_pos_x[0]) && (r_pos_y[3] == r_pos_y[0])) ||
                   ((r_pos_x[4] == r_pos_x[0]) && (r_pos_y[4] == r_pos_y[0]));

    // Move FSM state register.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Move FSM next-state logic; requests outside IDLE are simply not looked at.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (move_req) begin
                    w_next_state = S_CALC;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_tgt_ok) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_WAIT:  w_next_state = S_CHECK;
            S_CHECK: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Move FSM outputs decoded from the state register.
    always_comb begin
        busy     = 1'b0;
        move_ack = 1'b0;
        if (r_state != S_IDLE) begin
            busy = 1'b1;
        end else begin
            busy = 1'b0;
        end
        if (r_state == S_DONE) begin
            move_ack = 1'b1;
        end else begin
            move_ack = 1'b0;
        end
    end

    // Move datapath: latch request, issue wall query, commit or reject the step.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_pos_x   <= X_INIT;
            r_pos_y   <= Y_INIT;
            r_char    <= 3'd0;
            r_dir     <= 2'b00;
            r_orient  <= 1'b0;
            r_wall_x  <= 8'd0;
            r_wall_y  <= 8'd0;
            r_move_ok <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && move_req) begin
                r_char <= move_char;
                r_dir  <= move_dir;
            end
            if (r_state == S_CALC) begin
                // Facing follows the requested horizontal direction even if blocked.
                if ((r_char == 3'd0) && r_dir[1]) begin
                    r_orient <= r_dir[0];
                end
                if (w_tgt_ok) begin
                    r_wall_x <= w_tgt_x;
                    r_wall_y <= w_tgt_y;
                end else begin
                    r_move_ok <= 1'b0;
                end
            end
            if (r_state == S_CHECK) begin
                if (!wall_in) begin
                    for (int i = 0; i < 5; i++) begin
                        if (r_char == 3'(i)) begin
                            r_pos_x[i] <= r_wall_x;
                            r_pos_y[i] <= r_wall_y;
                        end
                    end
                    r_move_ok <= 1'b1;
                end else begin
                    r_move_ok <= 1'b0;
                end
            end
        end
    end

    // Registered collision flag, one cycle behind the positions.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= w_hit;
        end
    end

    assign pacman_orientation = r_orient;
    assign wall_x             = r_wall_x;
    assign wall_y             = r_wall_y;
    assign move_ok            = r_move_ok;
    assign collision          = r_collision;

endmodule
